vga_fifo_scan: RTL and testbench

// - 640x480@60 VGA scan-out stage; consumer of the SDRAM read-FIFO in sdfifo_ctrl.
// - Generates H/V timing, pops one RGB565 word per active pixel (rdfifo_rdreq) and expands it to 8:8:8 VGA.
// - Pulses rdfifo_clr once per frame in vertical blanking to realign the FIFO/read address to frame start.
// - Counts FIFO underflows.

---
 rtl/vga_fifo_scan.sv | 100 ++++++++++
 tb/tb_vga_fifo_scan.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fifo_scan.sv
// 640x480@60 VGA scan-out: H/V timing, one RGB565 FIFO pop per visible pixel,
// 8:8:8 expansion, per-frame FIFO realign pulse and saturating underflow count.
module vga_fifo_scan #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLR_LINE = 481
) (
    input  logic        clk_25m,
    input  logic        rst_n,
    input  logic [15:0] rdfifo_rddb,
    input  logic        rdfifo_empty,
    output logic        rdfifo_rdreq,
    output logic        rdfifo_clr,
    output logic        oHS,
    output logic        oVS,
    output logic        oBLANK_n,
    output logic [7:0]  r_data,
    output logic [7:0]  g_data,
    output logic [7:0]  b_data,
    output logic        frame_start,
    output logic [15:0] underflow_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] V_CLR  = VW'(CLR_LINE);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active;
    logic          underflow;

    // Raster position; reset parks it at the first blanking line so the
    // realign line always precedes the first pixel read.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= V_ACT;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    assign active       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign underflow    = active && rdfifo_empty;
    assign rdfifo_rdreq = active;
    assign rdfifo_clr   = (v_cnt == V_CLR);

    // Output stage, one cycle behind the counters to line up with FIFO data.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            oHS           <= 1'b1;
            oVS           <= 1'b1;
            oBLANK_n      <= 1'b0;
            frame_start   <= 1'b0;
            r_data        <= '0;
            g_data        <= '0;
            b_data        <= '0;
            underflow_cnt <= '0;
        end else begin
            oBLANK_n    <= active;
            oHS         <= !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
            oVS         <= !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            if (active && !rdfifo_empty) begin
                r_data <= {rdfifo_rddb[15:11], rdfifo_rddb[15:13]};
                g_data <= {rdfifo_rddb[10:5],  rdfifo_rddb[10:9]};
                b_data <= {rdfifo_rddb[4:0],   rdfifo_rddb[4:2]};
            end else begin
                r_data <= '0;
                g_data <= '0;
                b_data <= '0;
            end
            if (underflow && (underflow_cnt != 16'hFFFF)) begin
                underflow_cnt <= underflow_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_fifo_scan.sv
// Bench for vga_fifo_scan: a shrunk raster checked cycle by cycle against a
// position-arithmetic model, plus full-size and saturation instances.
module tb_vga_fifo_scan;

    // Shrunk raster for the cycle-accurate model
    localparam int M_HA = 16, M_HFP = 4, M_HS = 8, M_HBP = 4;
    localparam int M_VA = 12, M_VFP = 2, M_VS = 2, M_VBP = 3;
    localparam int M_CLR    = 13;
    localparam int M_HT     = M_HA + M_HFP + M_HS + M_HBP;
    localparam int M_VT     = M_VA + M_VFP + M_VS + M_VBP;
    localparam int M_FRAME  = M_HT * M_VT;
    localparam int M_START  = M_VA * M_HT;
    localparam int M_BLANK0 = (M_VT - M_VA) * M_HT;
    localparam int M_PIX    = M_HA * M_VA;

    // Dense raster used to reach counter saturation quickly
    localparam int B_HA = 250, B_HFP = 1, B_HS = 2, B_HBP = 3;
    localparam int B_VA = 250, B_VFP = 1, B_VS = 1, B_VBP = 2;
    localparam int B_HT    = B_HA + B_HFP + B_HS + B_HBP;
    localparam int B_FRAME = B_HT * (B_VA + B_VFP + B_VS + B_VBP);
    localparam int B_START = B_VA * B_HT;

    logic clk_25m;
    logic rst_a, rst_b;

    logic [15:0] rddb_a, rddb_b, rddb_c;
    logic        empty_a, empty_b, empty_c;
    logic        rdreq_a, rdreq_b, rdreq_c;
    logic        clr_a, clr_b, clr_c;
    logic        hs_a, hs_b, hs_c, vs_a, vs_b, vs_c;
    logic        blank_a, blank_b, blank_c;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic        fs_a, fs_b, fs_c;
    logic [15:0] ucnt_a, ucnt_b, ucnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    vga_fifo_scan #(
        .H_ACTIVE(M_HA), .H_FP(M_HFP), .H_SYNC(M_HS), .H_BP(M_HBP),
        .V_ACTIVE(M_VA), .V_FP(M_VFP), .V_SYNC(M_VS), .V_BP(M_VBP),
        .CLR_LINE(M_CLR)
    ) dut_a (
        .clk_25m(clk_25m), .rst_n(rst_a), .rdfifo_rddb(rddb_a), .rdfifo_empty(empty_a),
        .rdfifo_rdreq(rdreq_a), .rdfifo_clr(clr_a), .oHS(hs_a), .oVS(vs_a),
        .oBLANK_n(blank_a), .r_data(r_a), .g_data(g_a), .b_data(b_a),
        .frame_start(fs_a), .underflow_cnt(ucnt_a)
    );

    vga_fifo_scan #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .CLR_LINE(B_VA + 1)
    ) dut_b (
        .clk_25m(clk_25m), .rst_n(rst_b), .rdfifo_rddb(rddb_b), .rdfifo_empty(empty_b),
        .rdfifo_rdreq(rdreq_b), .rdfifo_clr(clr_b), .oHS(hs_b), .oVS(vs_b),
        .oBLANK_n(blank_b), .r_data(r_b), .g_data(g_b), .b_data(b_b),
        .frame_start(fs_b), .underflow_cnt(ucnt_b)
    );

    vga_fifo_scan dut_c (
        .clk_25m(clk_25m), .rst_n(rst_b), .rdfifo_rddb(rddb_c), .rdfifo_empty(empty_c),
        .rdfifo_rdreq(rdreq_c), .rdfifo_clr(clr_c), .oHS(hs_c), .oVS(vs_c),
        .oBLANK_n(blank_c), .r_data(r_c), .g_data(g_c), .b_data(b_c),
        .frame_start(fs_c), .underflow_cnt(ucnt_c)
    );

    initial clk_25m = 1'b0;
    always #20 clk_25m = ~clk_25m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_line(input int p); return p / M_HT; endfunction
    function automatic int m_col(input int p);  return p % M_HT; endfunction
    function automatic bit m_act(input int p);
        return (m_col(p) < M_HA) && (m_line(p) < M_VA);
    endfunction

    // Bit replication of an RGB565 word to 8:8:8, done with arithmetic
    function automatic logic [23:0] expand(input logic [15:0] d);
        int r5, g6, b5;
        r5 = int'(d) / 2048;
        g6 = (int'(d) / 32) % 64;
        b5 = int'(d) % 32;
        return 24'((r5 * 8 + r5 / 4) * 65536 + (g6 * 4 + g6 / 16) * 256 + (b5 * 8 + b5 / 4));
    endfunction

    initial begin
        logic [15:0] map_in  [4];
        logic [23:0] map_exp [4];
        map_in[0] = 16'hF800; map_exp[0] = 24'hFF0000;
        map_in[1] = 16'h07E0; map_exp[1] = 24'h00FF00;
        map_in[2] = 16'h001F; map_exp[2] = 24'h0000FF;
        map_in[3] = 16'h8410; map_exp[3] = 24'h848284;

        rst_a = 1'b0; rst_b = 1'b0;
        rddb_a = '0; empty_a = 1'b0;
        rddb_b = 16'h1234; empty_b = 1'b1;
        rddb_c = 16'hFFFF; empty_c = 1'b0;
        repeat (3) @(posedge clk_25m);
        @(negedge clk_25m);
        rst_a = 1'b1; rst_b = 1'b1;
        #1;

        fork
            begin : proc_main
                int k, p, pp, ucnt, pix, prev_pix, rd_cnt, hs_low;
                bit have_prev, pe, done, seen_clr, prev_clr, prev_hs, e;
                logic [15:0] pd, d;
                logic [23:0] exp_rgb;
                for (int phase = 0; phase < 2; phase++) begin
                    k = 0; pp = 0; ucnt = 0; pix = 0; prev_pix = 0; rd_cnt = 0; hs_low = 0;
                    have_prev = 0; pe = 0; pd = '0; done = 0; seen_clr = 0;
                    prev_clr = 0; prev_hs = 1;
                    while (!done) begin
                        p = (M_START + k) % M_FRAME;
                        check("rdreq", 32'(rdreq_a), 32'(m_act(p)));
                        check("clr", 32'(clr_a), 32'(m_line(p) == M_CLR));
                        if (have_prev) begin
                            if (m_act(pp) && pe) ucnt = (ucnt < 65535) ? ucnt + 1 : 65535;
                            exp_rgb = (m_act(pp) && !pe) ? expand(pd) : 24'h0;
                            check("blank_n", 32'(blank_a), 32'(m_act(pp)));
                            check("hs", 32'(hs_a), 32'(!(m_col(pp) >= M_HA + M_HFP &&
                                                      m_col(pp) < M_HA + M_HFP + M_HS)));
                            check("vs", 32'(vs_a), 32'(!(m_line(pp) >= M_VA + M_VFP &&
                                                      m_line(pp) < M_VA + M_VFP + M_VS)));
                            check("frame_start", 32'(fs_a), 32'(pp == 0));
                            check("rgb", 32'({r_a, g_a, b_a}), 32'(exp_rgb));
                            if (phase == 0 && m_act(pp) && prev_pix < 4)
                                check("map", 32'({r_a, g_a, b_a}), 32'(map_exp[prev_pix]));
                            if (phase == 0 && m_act(pp) && prev_pix == 30)
                                check("uf_burst", 32'(ucnt_a), 32'd10);
                        end else begin
                            check("rst_blank_n", 32'(blank_a), 32'd0);
                            check("rst_hs", 32'(hs_a), 32'd1);
                            check("rst_vs", 32'(vs_a), 32'd1);
                            check("rst_fs", 32'(fs_a), 32'd0);
                            check("rst_rgb", 32'({r_a, g_a, b_a}), 32'd0);
                        end
                        check("ucnt", 32'(ucnt_a), 32'(ucnt));

                        // Frame-level measurements against fixed timing numbers
                        if (rdreq_a) rd_cnt++;
                        if (prev_clr && !clr_a) begin
                            if (seen_clr) check("rdreq_per_frame", 32'(rd_cnt), 32'(M_PIX));
                            seen_clr = 1; rd_cnt = 0;
                        end
                        if (!hs_a) hs_low++;
                        if (hs_a && !prev_hs) begin
                            check("hs_low_width", 32'(hs_low), 32'(M_HS));
                            hs_low = 0;
                        end
                        prev_clr = clr_a; prev_hs = hs_a;

                        if (phase == 0 && k >= M_BLANK0 + 2 * M_FRAME && p == 5 * M_HT + 7) done = 1;
                        if (phase == 1 && k >= M_BLANK0 + 2 * M_FRAME) done = 1;
                        if (!done) begin
                            d = 16'($urandom);
                            if (m_act(p)) begin
                                e = (phase == 1 || pix >= M_PIX) && ($urandom_range(0, 7) == 0);
                                if (phase == 0 && pix < 4) d = map_in[pix];
                                if (phase == 0 && pix >= 20 && pix < 30) e = 1;
                            end else begin
                                e = (phase == 0 && k < M_BLANK0) ? 1'b1 : 1'($urandom_range(0, 1));
                            end
                            rddb_a = d; empty_a = e;
                            pp = p; pe = e; pd = d; prev_pix = pix; have_prev = 1;
                            if (m_act(p)) pix++;
                            @(posedge clk_25m); #1;
                            k++;
                        end
                    end
                    if (phase == 0) begin
                        // Asynchronous reset in the middle of a visible line
                        rst_a = 1'b0;
                        #2;
                        check("midrst_rdreq", 32'(rdreq_a), 32'd0);
                        check("midrst_clr", 32'(clr_a), 32'd0);
                        check("midrst_hs", 32'(hs_a), 32'd1);
                        check("midrst_vs", 32'(vs_a), 32'd1);
                        check("midrst_blank_n", 32'(blank_a), 32'd0);
                        check("midrst_rgb", 32'({r_a, g_a, b_a}), 32'd0);
                        check("midrst_fs", 32'(fs_a), 32'd0);
                        check("midrst_ucnt", 32'(ucnt_a), 32'd0);
                        @(negedge clk_25m);
                        @(negedge clk_25m);
                        rst_a = 1'b1;
                        #1;
                    end
                end
            end

            begin : proc_sat
                int mc, pb;
                mc = 0;
                for (int kb = 0; kb < 72000 && mc < 65535 + 300; kb++) begin
                    if (kb % 4096 == 0 || (mc >= 65530 && mc <= 65600)) begin
                        check("sat_ucnt", 32'(ucnt_b), 32'((mc > 65535) ? 65535 : mc));
                        check("sat_rgb", 32'({r_b, g_b, b_b}), 32'd0);
                    end
                    pb = (B_START + kb) % B_FRAME;
                    if ((pb % B_HT) < B_HA && (pb / B_HT) < B_VA) mc++;
                    @(posedge clk_25m); #1;
                end
                check("sat_final", 32'(ucnt_b), 32'h0000FFFF);
            end

            begin : proc_full
                for (int kc = 0; kc <= 36001; kc++) begin
                    case (kc)
                        0:     begin check("full_clr_0", 32'(clr_c), 32'd0);
                                     check("full_rdreq_0", 32'(rdreq_c), 32'd0); end
                        799:   check("full_clr_799", 32'(clr_c), 32'd0);
                        800:   check("full_clr_800", 32'(clr_c), 32'd1);
                        1599:  check("full_clr_1599", 32'(clr_c), 32'd1);
                        1600:  check("full_clr_1600", 32'(clr_c), 32'd0);
                        656:   check("full_hs_656", 32'(hs_c), 32'd1);
                        657:   check("full_hs_657", 32'(hs_c), 32'd0);
                        752:   check("full_hs_752", 32'(hs_c), 32'd0);
                        753:   check("full_hs_753", 32'(hs_c), 32'd1);
                        8000:  check("full_vs_8000", 32'(vs_c), 32'd1);
                        8001:  check("full_vs_8001", 32'(vs_c), 32'd0);
                        9600:  check("full_vs_9600", 32'(vs_c), 32'd0);
                        9601:  check("full_vs_9601", 32'(vs_c), 32'd1);
                        35999: check("full_rdreq_35999", 32'(rdreq_c), 32'd0);
                        36000: begin check("full_rdreq_36000", 32'(rdreq_c), 32'd1);
                                     check("full_blank_36000", 32'(blank_c), 32'd0); end
                        36001: check("full_blank_36001", 32'(blank_c), 32'd1);
                        default: ;
                    endcase
                    @(posedge clk_25m); #1;
                end
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
